// File: rtl/hsk_i2c_pkg.sv
// Shared I2C command encoding, arbiter state encoding and small helpers
// used by the byte master, the packet engine and the bus arbiter.
package hsk_i2c_pkg;

  localparam int STA   = 0;
  localparam int STO   = 1;
  localparam int WR    = 2;
  localparam int RD    = 3;
  localparam int ACK   = 4;
  localparam int CMD_W = 5;

  typedef struct packed {
    logic ack;
    logic rd;
    logic wr;
    logic sto;
    logic sta;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FSTOP = 3'd4,
    ST_FWAIT = 3'd5
  } state_e;

  localparam cmd_t CMD_FORCE_STOP = '{ack: 1'b0, rd: 1'b0, wr: 1'b0, sto: 1'b1, sta: 1'b0};

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/hsk_i2c_watchdog.sv
// Saturating hold-time counter; o_expire is high once TIMEOUT_CYCLES enabled
// cycles have elapsed since the last clear. Single-cycle clear, never wraps.
module hsk_i2c_watchdog
  import hsk_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 80000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (r_cnt == LIMIT);

endmodule

// File: rtl/hsk_i2c_arbiter.sv
// Two-way owner arbiter for the shared I2C byte master; grant visible one cycle after request,
// ownership lasts START..STOP, non-owners see no ready, stalled owners get a forced STOP.
module hsk_i2c_arbiter #(
  parameter int TIMEOUT_CYCLES = 80000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  req_valid_i,
  input  logic [9:0]  req_cmd_i,
  input  logic [15:0] req_dat_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_valid_o,
  output logic [7:0]  rsp_dat_o,
  output logic        rsp_nack_o,
  output logic        rsp_err_o,
  output logic        m_valid_o,
  output logic [4:0]  m_cmd_o,
  output logic [7:0]  m_dat_o,
  input  logic        m_ready_i,
  input  logic        m_done_i,
  input  logic [7:0]  m_dat_i,
  input  logic        m_nack_i,
  input  logic        m_al_i,
  input  logic        i2c_rdy_i,
  output logic        busy_o,
  output logic        owner_o
);

  import hsk_i2c_pkg::*;

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_HOLD  = ST_HOLD;
  localparam logic [2:0] S_FSTOP = ST_FSTOP;
  localparam logic [2:0] S_FWAIT = ST_FWAIT;

  logic [2:0]  r_state;
  logic        r_owner;
  logic        r_last;
  logic [1:0]  r_req_ready;
  logic [1:0]  r_rsp_valid;
  logic [7:0]  r_rsp_dat;
  logic        r_rsp_nack;
  logic        r_rsp_err;
  logic        r_m_valid;
  cmd_t        r_m_cmd;
  logic [7:0]  r_m_dat;
  logic        r_busy;

  logic [CMD_W-1:0] w_cmd [2];
  logic [7:0]       w_dat [2];
  logic             w_winner;
  logic             w_grant;
  logic             w_hold_acc;
  logic             w_wd_clr;
  logic             w_wd_en;
  logic             w_wd_expire;

  assign w_cmd[0] = req_cmd_i[4:0];
  assign w_cmd[1] = req_cmd_i[9:5];
  assign w_dat[0] = req_dat_i[7:0];
  assign w_dat[1] = req_dat_i[15:8];

  // On a tie the requester not served last wins.
  assign w_winner = (&req_valid_i) ? ~r_last : req_valid_i[1];

  // A ready pulse still on the wire means the requester has not yet dropped
  // valid for the command just consumed, so it must not be granted again.
  assign w_grant    = (r_state == S_IDLE) && i2c_rdy_i && (|req_valid_i) && (r_req_ready == 2'b00);
  assign w_hold_acc = (r_state == S_HOLD) && req_valid_i[r_owner];

  assign w_wd_clr = (r_state != S_HOLD) || w_hold_acc;
  assign w_wd_en  = (r_state == S_HOLD) && !w_hold_acc;

  hsk_i2c_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (wb_clk_i),
    .i_rst    (wb_rst_i),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_req_ready <= 2'b00;
      r_rsp_valid <= 2'b00;
      r_rsp_dat   <= 8'h00;
      r_rsp_nack  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_cmd     <= '0;
      r_m_dat     <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= 2'b00;
      r_rsp_valid <= 2'b00;
      // Lagging by one state keeps busy high through the final response pulse.
      r_busy      <= (r_state != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner     <= w_winner;
            r_req_ready <= req_onehot(w_winner);
            if (w_cmd[w_winner][STA]) begin
              r_m_cmd   <= cmd_t'(w_cmd[w_winner]);
              r_m_dat   <= w_dat[w_winner];
              r_m_valid <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              r_rsp_valid <= req_onehot(w_winner);
              r_rsp_dat   <= 8'h00;
              r_rsp_nack  <= 1'b0;
              r_rsp_err   <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          // Entered from HOLD with valid low: raise it one cycle after the accept.
          if (!r_m_valid) begin
            r_m_valid <= 1'b1;
          end else if (m_ready_i) begin
            r_m_valid <= 1'b0;
            r_state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (m_done_i) begin
            r_rsp_valid <= req_onehot(r_owner);
            r_rsp_dat   <= m_dat_i;
            r_rsp_nack  <= m_nack_i;
            r_rsp_err   <= m_al_i;
            if (m_al_i) begin
              r_state <= S_IDLE;
            end else if (r_m_cmd.sto) begin
              r_last  <= r_owner;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (w_hold_acc) begin
            r_req_ready <= req_onehot(r_owner);
            r_m_cmd     <= cmd_t'(w_cmd[r_owner]);
            r_m_dat     <= w_dat[r_owner];
            r_state     <= S_ISSUE;
          end else if (w_wd_expire) begin
            r_m_cmd   <= CMD_FORCE_STOP;
            r_m_dat   <= 8'h00;
            r_m_valid <= 1'b1;
            r_state   <= S_FSTOP;
          end
        end

        S_FSTOP: begin
          if (m_ready_i) begin
            r_m_valid <= 1'b0;
            r_state   <= S_FWAIT;
          end
        end

        S_FWAIT: begin
          if (m_done_i) begin
            r_rsp_valid <= req_onehot(r_owner);
            r_rsp_dat   <= m_dat_i;
            r_rsp_nack  <= m_nack_i;
            r_rsp_err   <= 1'b1;
            r_last      <= r_owner;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_m_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_nack_o  = r_rsp_nack;
  assign rsp_err_o   = r_rsp_err;
  assign m_valid_o   = r_m_valid;
  assign m_cmd_o     = r_m_cmd;
  assign m_dat_o     = r_m_dat;
  assign busy_o      = r_busy;
  assign owner_o     = r_owner;

endmodule

// File: tb/tb_hsk_i2c_arbiter.sv
// Directed bench for hsk_i2c_arbiter with a hand-driven master; watchdog shortened to 16 cycles.
module tb_hsk_i2c_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_cmd;
  logic [15:0] req_dat;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_dat;
  logic        rsp_nack;
  logic        rsp_err;
  logic        m_valid;
  logic [4:0]  m_cmd;
  logic [7:0]  m_dat;
  logic        m_ready;
  logic        m_done;
  logic [7:0]  m_rdat;
  logic        m_nack;
  logic        m_al;
  logic        i2c_rdy;
  logic        busy;
  logic        owner;

  int n_cmp = 0;
  int n_err = 0;

  hsk_i2c_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req_valid_i (req_valid),
    .req_cmd_i   (req_cmd),
    .req_dat_i   (req_dat),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_dat_o   (rsp_dat),
    .rsp_nack_o  (rsp_nack),
    .rsp_err_o   (rsp_err),
    .m_valid_o   (m_valid),
    .m_cmd_o     (m_cmd),
    .m_dat_o     (m_dat),
    .m_ready_i   (m_ready),
    .m_done_i    (m_done),
    .m_dat_i     (m_rdat),
    .m_nack_i    (m_nack),
    .m_al_i      (m_al),
    .i2c_rdy_i   (i2c_rdy),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a master command, checks it, then handshakes it.
  task automatic mhs(input string tag, input logic [4:0] c, input logic [7:0] d);
    int n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
    chk({tag, "_mcmd"}, 32'(m_cmd), 32'(c));
    chk({tag, "_mdat"}, 32'(m_dat), 32'(d));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic mdone(input logic [7:0] d, input logic nk, input logic al);
    m_done = 1'b1;
    m_rdat = d;
    m_nack = nk;
    m_al   = al;
    tick();
    m_done = 1'b0;
    m_nack = 1'b0;
    m_al   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_dat"}, 32'(rsp_dat), 32'd0);
    chk({tag, "_rsp_nack"}, 32'(rsp_nack), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_cmd"}, 32'(m_cmd), 32'd0);
    chk({tag, "_m_dat"}, 32'(m_dat), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_cmd = '0; req_dat = '0;
    m_ready = 1'b0; m_done = 1'b0; m_rdat = 8'h00; m_nack = 1'b0; m_al = 1'b0;
    i2c_rdy = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic write transaction from requester 0: sta|wr 0x80, then sto|wr 0x00.
    req_valid = 2'b01; req_cmd[4:0] = 5'b00101; req_dat[7:0] = 8'h80;
    tick();
    chk("t1_grant_ready", 32'(req_ready), 32'h1);
    chk("t1_grant_mvalid", 32'(m_valid), 32'h1);
    chk("t1_grant_busy", 32'(busy), 32'h1);
    req_valid = 2'b00;
    mhs("t1_start", 5'b00101, 8'h80);
    mdone(8'h5A, 1'b0, 1'b0);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_dat", 32'(rsp_dat), 32'h5A);
    chk("t1_rsp_nack", 32'(rsp_nack), 32'h0);
    chk("t1_busy_hold", 32'(busy), 32'h1);
    req_valid = 2'b01; req_cmd[4:0] = 5'b00110; req_dat[7:0] = 8'h00;
    tick();
    chk("t1_hold_ready", 32'(req_ready), 32'h1);
    chk("t1_hold_mvalid_late", 32'(m_valid), 32'h0);
    req_valid = 2'b00;
    tick();
    chk("t1_hold_mvalid", 32'(m_valid), 32'h1);
    mhs("t1_stop", 5'b00110, 8'h00);
    mdone(8'h00, 1'b0, 1'b0);
    chk("t1_stop_rsp", 32'(rsp_valid), 32'h1);
    chk("t1_stop_busy_still", 32'(busy), 32'h1);
    tick();
    chk("t1_busy_fall", 32'(busy), 32'h0);

    // Tie after reset goes to requester 0; requester 1 waits for the STOP.
    do_reset();
    req_valid = 2'b11; req_cmd = {5'b00101, 5'b00101}; req_dat = {8'h90, 8'h82};
    tick();
    chk("t2_tie1_ready", 32'(req_ready), 32'h1);
    chk("t2_tie1_owner", 32'(owner), 32'h0);
    req_valid = 2'b10;
    mhs("t2_r0_start", 5'b00101, 8'h82);
    mdone(8'h00, 1'b1, 1'b0);
    chk("t2_r0_nack", 32'(rsp_nack), 32'h1);
    tick();
    chk("t2_nonowner_blocked", 32'(req_ready), 32'h0);
    req_valid = 2'b11; req_cmd[4:0] = 5'b00110; req_dat[7:0] = 8'h00;
    tick();
    chk("t2_r0_stop_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b10;
    mhs("t2_r0_stop", 5'b00110, 8'h00);
    mdone(8'h00, 1'b0, 1'b0);
    chk("t2_r0_stop_rsp", 32'(rsp_valid), 32'h1);
    tick();
    chk("t2_r1_grant_ready", 32'(req_ready), 32'h2);
    chk("t2_r1_grant_owner", 32'(owner), 32'h1);
    req_valid = 2'b00;
    mhs("t2_r1_start", 5'b00101, 8'h90);
    mdone(8'h3C, 1'b0, 1'b0);
    chk("t2_r1_rsp", 32'(rsp_valid), 32'h2);
    chk("t2_r1_rsp_dat", 32'(rsp_dat), 32'h3C);
    req_valid = 2'b10; req_cmd[9:5] = 5'b00110; req_dat[15:8] = 8'h00;
    tick();
    chk("t2_r1_stop_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    mhs("t2_r1_stop", 5'b00110, 8'h00);
    mdone(8'h00, 1'b0, 1'b0);
    chk("t2_r1_stop_rsp", 32'(rsp_valid), 32'h2);
    tick();
    // Requester 1 served last: tie goes to 0, then the following tie to 1.
    req_valid = 2'b11; req_cmd = {5'b00111, 5'b00111}; req_dat = {8'h22, 8'h11};
    tick();
    chk("t2_tie2_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b10;
    mhs("t2_tie2_cmd", 5'b00111, 8'h11);
    mdone(8'h00, 1'b0, 1'b0);
    chk("t2_tie2_rsp", 32'(rsp_valid), 32'h1);
    req_valid = 2'b11;
    tick();
    chk("t2_tie3_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    mhs("t2_tie3_cmd", 5'b00111, 8'h22);
    mdone(8'h00, 1'b0, 1'b0);
    chk("t2_tie3_rsp", 32'(rsp_valid), 32'h2);
    tick();

    // Command without START in IDLE is rejected without touching the master.
    req_valid = 2'b10; req_cmd[9:5] = 5'b00100; req_dat[15:8] = 8'h44;
    tick();
    chk("t3_rej_ready", 32'(req_ready), 32'h2);
    chk("t3_rej_rsp", 32'(rsp_valid), 32'h2);
    chk("t3_rej_err", 32'(rsp_err), 32'h1);
    chk("t3_rej_mvalid", 32'(m_valid), 32'h0);
    chk("t3_rej_busy", 32'(busy), 32'h0);
    tick();
    chk("t3_rej_no_regrant", 32'(req_ready), 32'h0);
    chk("t3_rej_no_rsp", 32'(rsp_valid), 32'h0);
    chk("t3_rej_mvalid2", 32'(m_valid), 32'h0);
    req_valid = 2'b00;
    tick();

    // Owner goes silent after START: forced STOP after 16 HOLD cycles.
    req_valid = 2'b01; req_cmd[4:0] = 5'b00101; req_dat[7:0] = 8'h80;
    tick();
    chk("t4_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    mhs("t4_start", 5'b00101, 8'h80);
    mdone(8'h00, 1'b0, 1'b0);
    chk("t4_start_rsp", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 16; i++) tick();
    chk("t4_not_early", 32'(m_valid), 32'h0);
    tick();
    chk("t4_fstop_mvalid", 32'(m_valid), 32'h1);
    chk("t4_fstop_cmd", 32'(m_cmd), 32'h02);
    chk("t4_fstop_dat", 32'(m_dat), 32'h00);
    mhs("t4_fstop", 5'b00010, 8'h00);
    mdone(8'h00, 1'b0, 1'b0);
    chk("t4_to_rsp", 32'(rsp_valid), 32'h1);
    chk("t4_to_err", 32'(rsp_err), 32'h1);
    tick();
    chk("t4_busy_fall", 32'(busy), 32'h0);

    // Arbitration lost: error response, back to IDLE, no STOP.
    req_valid = 2'b10; req_cmd[9:5] = 5'b00101; req_dat[15:8] = 8'hA0;
    tick();
    chk("t5_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    mhs("t5_start", 5'b00101, 8'hA0);
    mdone(8'h00, 1'b0, 1'b1);
    chk("t5_al_rsp", 32'(rsp_valid), 32'h2);
    chk("t5_al_err", 32'(rsp_err), 32'h1);
    tick();
    chk("t5_al_busy", 32'(busy), 32'h0);
    tick();
    tick();
    chk("t5_no_stop", 32'(m_valid), 32'h0);

    // I2C_RDY low holds off the grant until it rises.
    i2c_rdy = 1'b0;
    req_valid = 2'b01; req_cmd[4:0] = 5'b00101; req_dat[7:0] = 8'h55;
    tick();
    tick();
    tick();
    chk("t5_rdy_low_ready", 32'(req_ready), 32'h0);
    chk("t5_rdy_low_mvalid", 32'(m_valid), 32'h0);
    i2c_rdy = 1'b1;
    tick();
    chk("t5_rdy_high_ready", 32'(req_ready), 32'h1);
    chk("t5_rdy_high_mvalid", 32'(m_valid), 32'h1);
    req_valid = 2'b00;

    // Reset while ISSUE is waiting on the master.
    rst = 1'b1;
    tick();
    chk_reset_outputs("t6_rst");
    rst = 1'b0;
    req_valid = 2'b11; req_cmd = {5'b00101, 5'b00101}; req_dat = {8'h66, 8'h77};
    tick();
    chk("t6_post_rst_ready", 32'(req_ready), 32'h1);
    chk("t6_post_rst_mdat", 32'(m_dat), 32'h77);
    req_valid = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hsk_i2c_arbiter.md
# hsk_i2c_arbiter

Shares the single byte-level I2C master driving F_SDA/F_SCL between two requesters: requester 0 is the housekeeping packet engine (COBS/UART side) and requester 1 is the Wishbone register path. Ownership spans a full I2C transaction, from the command carrying START to the completion of the command carrying STOP, so SURF/TURFIO register accesses are never interleaved. A hold-timeout watchdog forces a STOP if an owner stalls mid-transaction. New grants are gated on I2C_RDY.

## Interface
- TIMEOUT_CYCLES, 80000, max idle cycles an owner may hold the bus between commands (1 ms at 80 MHz)
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  2  per-requester command valid
- req_cmd_i  in  10  two 5-bit commands {ack,rd,wr,sto,sta}; requester n at [5n+4:5n]
- req_dat_i  in  16  write byte; requester n at [8n+7:8n]
- req_ready_o  out  2  one-cycle accept pulse
- rsp_valid_o  out  2  one-cycle response pulse to the requester that issued the command
- rsp_dat_o  out  8  read byte; valid with rsp_valid_o
- rsp_nack_o  out  1  slave NACKed; valid with rsp_valid_o
- rsp_err_o  out  1  rejected, timed out or arbitration lost; valid with rsp_valid_o
- m_valid_o / m_cmd_o[4:0] / m_dat_o[7:0]  out  command to master
- m_ready_i  in  1  master accepts command
- m_done_i  in  1  command complete pulse; qualifies m_dat_i[7:0], m_nack_i, m_al_i
- i2c_rdy_i  in  1  I2C_RDY; low blocks new grants
- busy_o  out  1  bus owned
- owner_o  out  1  current/last owner index

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, FSTOP, FWAIT.
- IDLE: if i2c_rdy_i and any req_valid_i, pick the winner. On a tie, pick the requester not served last (reset value of last-served = 1, so requester 0 wins the first tie). Register owner and command.
  - If the winner's command lacks sta: pulse req_ready_o and rsp_valid_o with rsp_err_o=1; stay IDLE.
  - Otherwise pulse req_ready_o and go to ISSUE.
- ISSUE: hold m_valid_o with the latched cmd/dat until m_ready_i, then go to WAIT.
- WAIT: on m_done_i, pulse rsp_valid_o[owner] with m_dat_i/m_nack_i, and rsp_err_o=m_al_i.
  - If m_al_i: go to IDLE, no STOP.
  - Else if the command had sto: go to IDLE and update last-served.
  - Else go to HOLD.
- HOLD: only the owner's req_valid_i is considered; the non-owner sees req_ready_o=0. An owner command is accepted (ready pulse) and goes to ISSUE; sta within HOLD is a repeated start and is allowed. The watchdog counts each HOLD cycle without an accept. At TIMEOUT_CYCLES, go to FSTOP.
- FSTOP: issue cmd sto=1 with m_dat_o=0 and wait for m_ready_i, then go to FWAIT.
- FWAIT: on m_done_i, pulse rsp_valid_o[owner] with rsp_err_o=1, go to IDLE, update last-served.
- i2c_rdy_i low affects only the IDLE grant. Transactions in progress complete.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1). It clears on every HOLD entry and every accept. It saturates and never wraps.

## Timing
- Reset values:
  - outputs: req_ready_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_nack_o=0, rsp_err_o=0, m_valid_o=0, m_cmd_o=0, m_dat_o=0, busy_o=0, owner_o=0
  - state: IDLE, last-served=1
- Reset mid-transaction drops m_valid_o the cycle after wb_rst_i is sampled. No STOP is generated; the master is reset by the same wb_rst_i.
- Grant latency: req_valid_i sampled at cycle N in IDLE → req_ready_o and m_valid_o both high at N+1.
- Accept in HOLD: valid at N → ready at N+1 → m_valid_o at N+2.
- rsp_valid_o rises the cycle after m_done_i.
- Requesters hold valid/cmd/dat stable until ready. Ready is never given without valid.
- m_valid_o stays high and m_cmd_o/m_dat_o stay stable until m_ready_i.
- busy_o is high in every state except IDLE. It falls the cycle after the final rsp_valid_o.
- Timeout fires exactly TIMEOUT_CYCLES cycles after HOLD entry if no owner command arrives.
- Simultaneous owner command and timeout on the same cycle: the command wins.

## Structure
- Package hsk_i2c_pkg:
  - command bit indices STA=0, STO=1, WR=2, RD=3, ACK=4, shared with the master and packet engine
  - command struct typedef
  - state enum
- Sub-module hsk_i2c_watchdog: saturating counter with clear/enable inputs and an expire output, parameterized by TIMEOUT_CYCLES.

## Test plan
- Req0 cmd sta|wr, dat 0x80 (write to addr 0x40) → m_cmd sta|wr, 0x80; done with nack=0 → rsp_valid_o=2'b01, busy_o=1. Then cmd sto|wr, 0x00 → after done, busy_o=0.
- Req0 and req1 both valid with sta in the same cycle after reset → req0 granted. Req1 ready stays 0 until req0's STOP completes, then req1 is granted immediately. A second tie → req0 (round-robin).
- Req1 cmd wr without sta in IDLE → req_ready_o=2'b10 and rsp_valid_o=2'b10 with rsp_err_o=1; m_valid_o never asserts.
- TIMEOUT_CYCLES=16: req0 sends a START then goes silent → 16 cycles later m_cmd=sto. On done, rsp_err_o=1 to req0 and busy_o=0.
- Master returns m_al_i=1 on a write → rsp_err_o=1, state IDLE, no STOP issued. Separately, i2c_rdy_i=0 with req pending → no grant until i2c_rdy_i rises.
- wb_rst_i asserted while in ISSUE → the next cycle all outputs are at their reset values, and the next grant goes to req0.
